// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer,
// synchronous flush and a saturating stall counter.
module pipe_skid_reg #(
    parameter int unsigned       CTRL_W     = 10,
    parameter int unsigned       DATA_W     = 144,
    parameter logic [CTRL_W-1:0] CTRL_RESET = '0,
    parameter int unsigned       STALL_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_data,
    output logic [STALL_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        SKID
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CTRL_W-1:0]  main_ctrl;
    logic [DATA_W-1:0]  main_data;
    logic [CTRL_W-1:0]  skid_ctrl;
    logic [DATA_W-1:0]  skid_data;
    logic               in_acc;
    logic               out_acc;
    logic [STALL_W-1:0] stall_q;

    always_comb begin
        in_acc  = in_valid & in_ready;
        out_acc = out_valid & out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (in_acc) state_next = FULL;
            FULL: begin
                if (in_acc && !out_acc) begin
                    state_next = SKID;
                end else if (!in_acc && out_acc) begin
                    state_next = EMPTY;
                end
            end
            SKID: if (out_acc) state_next = FULL;
            default: state_next = EMPTY;
        endcase
    end

    // Handshake flags decode registered state only, so out_ready never reaches in_ready.
    always_comb begin
        in_ready    = (state != SKID);
        out_valid   = (state != EMPTY);
        out_ctrl    = main_ctrl;
        out_data    = main_data;
        stall_count = stall_q;
    end

    // Main is reloaded with the bubble on every entry to EMPTY, so out_* need no masking.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_ctrl <= CTRL_RESET;
            main_data <= '0;
            skid_ctrl <= CTRL_RESET;
            skid_data <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_acc) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end
                end
                FULL: begin
                    if (in_acc && out_acc) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (in_acc) begin
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                    end else if (out_acc) begin
                        main_ctrl <= CTRL_RESET;
                        main_data <= '0;
                    end
                end
                SKID: begin
                    if (out_acc) begin
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                    end
                end
                default: begin
                    main_ctrl <= CTRL_RESET;
                    main_data <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

endmodule
